toggle_edge_counter: RTL and testbench
======================================

Name: toggle_edge_counter

Overview:
Downstream consumer of the t_flipflop stage. Counts rising edges of the flip-flop's q output over a programmable gate window of clk cycles, then reports the count with a done/ack handshake. Used to check toggle rate and divider ratio of the T stage in-system. Single clock domain: q_in is produced on the same clk, so there is no synchronizer.

Parameters:
CNT_W, 16, width of edge count result
GATE_W, 16, width of gate window length in clk cycles

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
q_in  input  1  q from t_flipflop stage
start  input  1  request measurement; sampled only in IDLE
gate_len  input  GATE_W  window length in cycles; latched on accepted start
ack  input  1  consumer acknowledges result; sampled only in HOLD
count  output  CNT_W  number of rising edges seen in window (saturating)
busy  output  1  high in ARM and COUNT
done  output  1  high in HOLD; result valid
overflow  output  1  count saturated during this window

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset takes effect at the next clk edge with rst=1 and holds while rst=1:
  - state=IDLE; count=0, busy=0, done=0, overflow=0.
  - q_prev=0; remaining-cycle counter=0.
  - Reset in any state, including mid-window, aborts the measurement; no done pulse is produced.
- q_prev register: q_prev <= q_in every cycle outside reset. Edge detect: rise = q_in & ~q_prev.
- FSM states IDLE, ARM, COUNT, HOLD:
  - IDLE: start=1 -> ARM. On this transition, latch gate_len into rem, clear count and overflow.
  - ARM: one cycle. Establishes the q_prev baseline, so a level already high at start is not counted. Edges are not counted in ARM. If rem==0 -> HOLD, else -> COUNT.
  - COUNT: each cycle, if rise then count <= count+1, unless count is all-ones. In that case count holds and overflow <= 1 (sticky until next accepted start). rem <= rem-1. When rem==1 -> HOLD; an edge in that final cycle is counted.
  - HOLD: done=1; count and overflow stable. ack=1 -> IDLE, done drops the next cycle. count and overflow keep their value in IDLE until the next accepted start.
- Window length: exactly gate_len COUNT cycles. done rises gate_len+2 cycles after the cycle start is sampled (gate_len=0 -> 2 cycles).
- start outside IDLE is ignored. ack outside HOLD is ignored.
- start and ack both high in HOLD: ack is taken, go to IDLE; start is not accepted that cycle.
- gate_len changes after acceptance have no effect on the current window.
- Arithmetic: count is unsigned and saturates at 2^CNT_W-1, never wraps. rem is GATE_W bits, with max window 2^GATE_W-1.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- t_flipflop driven with t=1, q_in toggling every cycle; start with gate_len=20 -> busy for 21 cycles, done after 22; count=10, overflow=0.
- t=0 (q_in constant 1 before start); gate_len=20 -> count=0, since the high level at ARM is not counted as an edge.
- CNT_W=4, t=1, gate_len=40 -> count=15 (saturated, not wrapped), overflow=1. The next start with gate_len=10 gives count=5, overflow=0.
- gate_len=0 with start -> ARM then HOLD: done=1 two cycles after start, count=0. Hold ack low 5 cycles -> done stays 1 and count stable; ack=1 -> done=0 the following cycle.
- rst=1 for one cycle mid-COUNT (cycle 8 of 20) -> next cycle IDLE, all outputs 0, no done. A new start then measures a clean 20-cycle window, count=10.
- start pulsed repeatedly during COUNT and in HOLD together with ack -> exactly one measurement completes, and the FSM returns to IDLE without re-arming.

Source files
------------

// File: rtl/toggle_edge_counter.sv
// Counts rising edges of q_in over a programmable window of clk cycles,
// then holds the result behind a done/ack handshake until acknowledged.
module toggle_edge_counter #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ack,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    HOLD
  } state_t;

  state_t            state;
  logic              q_prev;
  logic [GATE_W-1:0] rem;
  logic              rise;

  assign rise = q_in & ~q_prev;

  // ARM exists only to load q_prev with the level present at start, so a
  // q_in that is already high is never mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q_prev   <= 1'b0;
      rem      <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      q_prev <= q_in;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            rem      <= gate_len;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        ARM: begin
          if (rem == '0) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (rise) begin
            if (&count) begin
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          rem <= rem - 1'b1;
          // The edge seen in the final window cycle is still counted above.
          if (rem == GATE_W'(1)) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        HOLD: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_edge_counter.sv
// Scoreboard bench for toggle_edge_counter: directed measurements push the
// hand-computed result, a monitor pops and compares on each rising done.
module tb_toggle_edge_counter;

  localparam int CNT_W  = 4;
  localparam int GATE_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              q_in = 1'b0;
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              ack;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              overflow;

  logic t;
  logic q_load;
  logic q_load_val;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  logic done_q = 1'b0;

  toggle_edge_counter #(
    .CNT_W (CNT_W),
    .GATE_W(GATE_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .start   (start),
    .gate_len(gate_len),
    .ack     (ack),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Stand-in for the upstream T flip-flop, clocked on the same edge.
  always @(posedge clk) begin
    if (q_load) q_in <= q_load_val;
    else if (t) q_in <= ~q_in;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_q = 1'b0;
    end else begin
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("sb_count", 32'(count), 32'(e.cnt));
          check_output("sb_overflow", 32'(overflow), 32'(e.ovf));
        end
      end
      done_q = done;
    end
  end

  // Issues one start, then verifies busy length and done latency.
  task automatic apply_stimulus(input int gl, input logic [CNT_W-1:0] ec, input logic eo,
                                input string tag, input bit noisy);
    exp_t e;
    int   k;
    int   nbusy;
    e.cnt = ec;
    e.ovf = eo;
    exp_q.push_back(e);
    start    = 1'b1;
    gate_len = GATE_W'(gl);
    @(negedge clk);
    start    = 1'b0;
    gate_len = '1;
    check_output({tag, "_busy_arm"}, 32'(busy), 32'd1);
    k     = 1;
    nbusy = 0;
    while (!done && k < gl + 10) begin
      if (busy) nbusy++;
      if (noisy) begin
        start = (k % 3 == 0);
        ack   = (k % 4 == 0);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    ack   = 1'b0;
    check_output({tag, "_done_latency"}, 32'(k), 32'(gl + 2));
    check_output({tag, "_busy_cycles"}, 32'(nbusy), 32'(gl + 1));
    check_output({tag, "_busy_in_hold"}, 32'(busy), 32'd0);
  endtask

  task automatic ack_result(input string tag, input logic [CNT_W-1:0] ec);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_output({tag, "_done_after_ack"}, 32'(done), 32'd0);
    check_output({tag, "_count_idle"}, 32'(count), 32'(ec));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    ack        = 1'b0;
    gate_len   = '0;
    t          = 1'b0;
    q_load     = 1'b1;
    q_load_val = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    rst    = 1'b0;
    q_load = 1'b0;
    t      = 1'b1;
    @(negedge clk);

    // q_in toggling every cycle: 20 window cycles hold 10 rising edges.
    apply_stimulus(20, 4'd10, 1'b0, "toggle20", 1'b0);
    ack_result("toggle20", 4'd10);

    // q_in parked high before start: the level is not an edge.
    t          = 1'b0;
    q_load     = 1'b1;
    q_load_val = 1'b1;
    @(negedge clk);
    q_load = 1'b0;
    @(negedge clk);
    apply_stimulus(20, 4'd0, 1'b0, "level_high", 1'b0);
    ack_result("level_high", 4'd0);

    // 20 edges into a 4-bit counter saturate at 15; next window is clean.
    t = 1'b1;
    apply_stimulus(40, 4'd15, 1'b1, "saturate", 1'b0);
    ack_result("saturate", 4'd15);
    check_output("saturate_ovf_idle", 32'(overflow), 32'd1);
    apply_stimulus(10, 4'd5, 1'b0, "after_sat", 1'b0);
    ack_result("after_sat", 4'd5);

    // Zero-length window, result held while ack stays low.
    apply_stimulus(0, 4'd0, 1'b0, "gate0", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("gate0_done_hold", 32'(done), 32'd1);
      check_output("gate0_count_hold", 32'(count), 32'd0);
    end
    ack_result("gate0", 4'd0);

    // Reset during cycle 8 of a 20-cycle window aborts it.
    start    = 1'b1;
    gate_len = GATE_W'(20);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check_output("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_count", 32'(count), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_overflow", 32'(overflow), 32'd0);
    repeat (30) @(negedge clk);
    check_output("abort_no_done", 32'(done), 32'd0);
    apply_stimulus(20, 4'd10, 1'b0, "post_abort", 1'b0);
    ack_result("post_abort", 4'd10);

    // Stray start/ack during COUNT, then start together with ack in HOLD.
    apply_stimulus(20, 4'd10, 1'b0, "noisy", 1'b1);
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    check_output("noisy_done_after_ack", 32'(done), 32'd0);
    check_output("noisy_busy_after_ack", 32'(busy), 32'd0);
    @(negedge clk);
    check_output("noisy_not_rearmed", 32'(busy), 32'd0);
    repeat (25) @(negedge clk);
    check_output("noisy_still_idle", 32'(done), 32'd0);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
